// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: holds decoded operands and control for EX, supports stall/flush and
// flags load-use hazards. Optional ID_EX_PERF_CNT_EN adds stall/bubble performance counters.
module id_ex_pipeline_reg #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_rd1,
  input  logic [XLEN-1:0]       id_rd2,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [3:0]            id_funct,
  input  logic [1:0]            id_aluop,
  input  logic [5:0]            id_ctrl,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_rd1,
  output logic [XLEN-1:0]       ex_rd2,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [3:0]            ex_funct,
  output logic [1:0]            ex_aluop,
  output logic [5:0]            ex_ctrl,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_bubble_cnt,
`endif
  output logic                  hazard_stall
);

  // ctrl bit order: {Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite}
  localparam int unsigned MEMREAD_BIT = 4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
      ex_funct <= '0;
      ex_aluop <= '0;
      ex_ctrl  <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
      ex_funct <= '0;
      ex_aluop <= '0;
      ex_ctrl  <= '0;
    end else if (!stall) begin
      ex_valid <= id_valid;
      ex_pc    <= id_pc;
      ex_rd1   <= id_rd1;
      ex_rd2   <= id_rd2;
      ex_imm   <= id_imm;
      ex_rs1   <= id_rs1;
      ex_rs2   <= id_rs2;
      ex_rd    <= id_rd;
      ex_funct <= id_funct;
      // An invalid ID slot becomes a bubble: no stray writes reach MEM/WB
      ex_aluop <= id_valid ? id_aluop : '0;
      ex_ctrl  <= id_valid ? id_ctrl  : '0;
    end
  end

  always_comb begin
    hazard_stall = ex_valid & ex_ctrl[MEMREAD_BIT] & (ex_rd != '0)
                 & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  end

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (stall && !flush)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush || (!stall && !id_valid))
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Self-checking bench for id_ex_pipeline_reg: directed vectors, a field-level reference model
// compared every cycle, and literal spot checks. Covers ID_EX_PERF_CNT_EN when defined.
module tb_id_ex_pipeline_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [63:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_funct;
  logic [1:0]  id_aluop;
  logic [5:0]  id_ctrl;
  logic        ex_valid;
  logic [63:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_funct;
  logic [1:0]  ex_aluop;
  logic [5:0]  ex_ctrl;
  logic        hazard_stall;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  id_ex_pipeline_reg #(.XLEN(64), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
    .id_aluop(id_aluop), .id_ctrl(id_ctrl),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .ex_aluop(ex_aluop), .ex_ctrl(ex_ctrl),
`ifdef ID_EX_PERF_CNT_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt),
`endif
    .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction slot EX is expected to hold
  typedef struct {
    bit        valid;
    bit [63:0] pc, rd1, rd2, imm;
    bit [4:0]  rs1, rs2, rd;
    bit [3:0]  funct;
    bit [1:0]  aluop;
    bit [5:0]  ctrl;
  } slot_t;

  slot_t empty_slot;
  slot_t m;
  int unsigned m_stall_cnt = 0;
  int unsigned m_bubble_cnt = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m = empty_slot;
      m_stall_cnt = 0;
      m_bubble_cnt = 0;
    end else if (flush) begin
      m = empty_slot;
      m_bubble_cnt++;
    end else if (stall) begin
      m_stall_cnt++;
    end else begin
      m.valid = id_valid;
      m.pc = id_pc; m.rd1 = id_rd1; m.rd2 = id_rd2; m.imm = id_imm;
      m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd; m.funct = id_funct;
      m.aluop = id_valid ? id_aluop : 2'b00;
      m.ctrl  = id_valid ? id_ctrl  : 6'b0;
      if (!id_valid) m_bubble_cnt++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all registered outputs plus the hazard flag
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [283:0] act_v, exp_v;
      logic         exp_hz;
      act_v = {ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_funct, ex_aluop, ex_ctrl};
      exp_v = {m.valid, m.pc, m.rd1, m.rd2, m.imm, m.rs1, m.rs2, m.rd,
               m.funct, m.aluop, m.ctrl};
      exp_hz = m.valid && m.ctrl[4] && (m.rd != 0) && (m.rd == id_rs1 || m.rd == id_rs2);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL ex_state: got %h expected %h at %0t", act_v, exp_v, $time);
      end
      chk("hazard_stall", {63'd0, hazard_stall}, {63'd0, exp_hz});
`ifdef ID_EX_PERF_CNT_EN
      chk("perf_stall_cnt", {32'd0, perf_stall_cnt}, {32'd0, m_stall_cnt});
      chk("perf_bubble_cnt", {32'd0, perf_bubble_cnt}, {32'd0, m_bubble_cnt});
`endif
    end
  end

  task automatic set_id(input bit v, input bit [63:0] pc, input bit [4:0] rs1, input bit [4:0] rs2,
                        input bit [4:0] rd, input bit [3:0] f, input bit [1:0] op, input bit [5:0] c);
    id_valid = v; id_pc = pc; id_rd1 = pc ^ 64'hA5A5_0000_1111_2222; id_rd2 = ~pc;
    id_imm = {32'hFFFF_FFFF, pc[31:0]}; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_funct = f; id_aluop = op; id_ctrl = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {63'd0, ex_valid}, 64'd0);
    chk({tag, "_pc"}, ex_pc, 64'd0);
    chk({tag, "_ctrl"}, {58'd0, ex_ctrl}, 64'd0);
    chk({tag, "_aluop"}, {62'd0, ex_aluop}, 64'd0);
    chk({tag, "_rd"}, {59'd0, ex_rd}, 64'd0);
    chk({tag, "_hazard"}, {63'd0, hazard_stall}, 64'd0);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    set_id(1'b0, 64'd0, 5'd0, 5'd0, 5'd0, 4'd0, 2'd0, 6'd0);
    step();
    cmp_en = 1'b1;
    chk_all_zero("reset");
    reset = 1'b1;

`ifdef ID_EX_PERF_CNT_EN
    // 4 stall edges then 2 flush edges from a fresh reset
    set_id(1'b1, 64'h40, 5'd1, 5'd2, 5'd3, 4'd0, 2'd0, 6'd1);
    stall = 1'b1;
    repeat (4) step();
    stall = 1'b0; flush = 1'b1;
    repeat (2) step();
    flush = 1'b0;
    chk("perf_stall_4", {32'd0, perf_stall_cnt}, 64'd4);
    chk("perf_bubble_2", {32'd0, perf_bubble_cnt}, 64'd2);
    // wrap of the stall counter
    @(negedge clk);
    cmp_en = 1'b0;
    force dut.perf_stall_cnt = 32'hFFFF_FFFF;
    #1 release dut.perf_stall_cnt;
    m_stall_cnt = 32'hFFFF_FFFF;
    stall = 1'b1;
    step();
    stall = 1'b0;
    chk("perf_stall_wrap", {32'd0, perf_stall_cnt}, 64'd0);
    @(negedge clk);
    cmp_en = 1'b1;
`endif

    // Basic load: one-cycle latency, fields passed through
    set_id(1'b1, 64'h1000, 5'd1, 5'd2, 5'd7, 4'b1000, 2'b10, 6'b000001);
    step();
    chk("load_aluop", {62'd0, ex_aluop}, 64'd2);
    chk("load_funct", {60'd0, ex_funct}, 64'd8);
    chk("load_rd", {59'd0, ex_rd}, 64'd7);
    chk("load_ctrl", {58'd0, ex_ctrl}, 64'd1);
    chk("load_valid", {63'd0, ex_valid}, 64'd1);
    chk("load_pc", ex_pc, 64'h1000);

    // Stall holds for 3 cycles while ID changes
    set_id(1'b1, 64'h1004, 5'd3, 5'd4, 5'd9, 4'b0000, 2'b00, 6'b000011);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold_rd", {59'd0, ex_rd}, 64'd7);
    end
    stall = 1'b0;
    step();
    chk("after_stall_rd", {59'd0, ex_rd}, 64'd9);
    chk("after_stall_pc", ex_pc, 64'h1004);

    // Flush beats stall
    set_id(1'b1, 64'h2000, 5'd5, 5'd6, 5'd8, 4'b1111, 2'b11, 6'b111111);
    flush = 1'b1; stall = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0;
    chk("flush_ctrl", {58'd0, ex_ctrl}, 64'd0);
    chk("flush_aluop", {62'd0, ex_aluop}, 64'd0);
    chk("flush_valid", {63'd0, ex_valid}, 64'd0);
    chk("flush_rd", {59'd0, ex_rd}, 64'd0);

    // Load-use hazard: ld x5 in EX
    set_id(1'b1, 64'h3000, 5'd1, 5'd2, 5'd5, 4'b0011, 2'b00, 6'b011011);
    step();
    id_rs1 = 5'd1; id_rs2 = 5'd5;
    #1 chk("hazard_rs2", {63'd0, hazard_stall}, 64'd1);
    id_rs1 = 5'd5; id_rs2 = 5'd6;
    #1 chk("hazard_rs1", {63'd0, hazard_stall}, 64'd1);
    id_rs1 = 5'd6;
    #1 chk("hazard_nomatch", {63'd0, hazard_stall}, 64'd0);
    set_id(1'b1, 64'h3004, 5'd0, 5'd0, 5'd0, 4'b0011, 2'b00, 6'b011011);
    step();
    id_rs1 = 5'd0; id_rs2 = 5'd0;
    #1 chk("hazard_rd0", {63'd0, hazard_stall}, 64'd0);
    set_id(1'b0, 64'h3008, 5'd1, 5'd2, 5'd5, 4'b0011, 2'b00, 6'b011011);
    step();
    id_rs2 = 5'd5;
    #1 chk("hazard_invalid", {63'd0, hazard_stall}, 64'd0);

    // id_valid=0 bubble with all control bits set
    set_id(1'b0, 64'h4000, 5'd10, 5'd11, 5'd12, 4'b0101, 2'b11, 6'b111111);
    step();
    chk("bubble_ctrl", {58'd0, ex_ctrl}, 64'd0);
    chk("bubble_aluop", {62'd0, ex_aluop}, 64'd0);
    chk("bubble_rd", {59'd0, ex_rd}, 64'd12);
    chk("bubble_funct", {60'd0, ex_funct}, 64'd5);

    // Mixed directed sequence checked by the per-cycle model
    for (int i = 0; i < 24; i++) begin
      set_id(i % 5 != 0, 64'h5000 + 64'(i * 4), 5'(i), 5'(i + 3), 5'(i % 4),
             4'(i), 2'(i), 6'(i * 7));
      stall = (i % 4 == 1);
      flush = (i % 7 == 3);
      step();
    end
    stall = 1'b0; flush = 1'b0;

    // Asynchronous reset between edges
    set_id(1'b1, 64'h6000, 5'd1, 5'd2, 5'd5, 4'b0010, 2'b10, 6'b011011);
    step();
    chk("pre_areset_valid", {63'd0, ex_valid}, 64'd1);
    #2 reset = 1'b0;
    #1 chk_all_zero("areset");
    stall = 1'b1; flush = 1'b1;
    step();
    chk_all_zero("areset_hold");
    stall = 1'b0; flush = 1'b0;
    reset = 1'b1;
    step();
    chk("post_reset_pc", ex_pc, 64'h6000);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
